intt_sched: RTL and testbench

//  Sequencer for the combinational INTT processing element (s = ((a +/- b) mod q) * c mod q).

---
 rtl/intt_pkg.sv | 21 ++
 rtl/intt_addr_gen.sv | 30 +++
 rtl/intt_sched.sv | 153 +++++++++++++++
 tb/tb_intt_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_pkg.sv
// Shared constants for the INTT sequencer: FSM state encoding, modulus and default n^-1.
// The optional scaling pass is selected with the INTT_SCALE_EN macro in intt_sched.
package intt_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] SUM    = 3'd2;
    localparam logic [2:0] DIF    = 3'd3;
    localparam logic [2:0] SCL_RD = 3'd4;
    localparam logic [2:0] SCL_WR = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam int Q         = 257;
    localparam int N_INV_DEF = 225;

    // Width of the stage counter; kept at least one bit for tiny transforms.
    function automatic int stage_w(input int logn);
        return (logn > 1) ? $clog2(logn) : 1;
    endfunction

endpackage

// File: rtl/intt_addr_gen.sv
// Gentleman-Sande butterfly index generator: maps (stage, butterfly) to the
// RAM pair (ia, ib) and the twiddle ROM index t.
module intt_addr_gen
    import intt_pkg::*;
#(
    parameter int LOGN = 3,
    parameter int SW   = stage_w(LOGN)
) (
    input  logic [SW-1:0]   stage,
    input  logic [LOGN-2:0] bf,
    output logic [LOGN-1:0] ia,
    output logic [LOGN-1:0] ib,
    output logic [LOGN-2:0] t
);

    logic [LOGN-1:0] bfx;
    logic [LOGN-1:0] hi_bit;
    logic [LOGN-1:0] lo_mask;

    // ia is bf with a zero spliced in at bit 'stage'; ib sets that bit.
    always_comb begin
        bfx     = {1'b0, bf};
        hi_bit  = LOGN'(1) << stage;
        lo_mask = hi_bit - LOGN'(1);
        ia      = ((bfx & ~lo_mask) << 1) | (bfx & lo_mask);
        ib      = ia | hi_bit;
        t       = (bf & lo_mask[LOGN-2:0]) << (SW'(LOGN - 1) - stage);
    end

endmodule

// File: rtl/intt_sched.sv
// Sequencer for an in-place Gentleman-Sande inverse NTT driving an external PE,
// coefficient RAM and twiddle ROM. Define INTT_SCALE_EN to append the n^-1 scaling pass.
module intt_sched
    import intt_pkg::*;
#(
    parameter int W     = 9,
    parameter int LOGN  = 3,
    parameter int N_INV = N_INV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    input  logic [W-1:0]    rd_data_a,
    input  logic [W-1:0]    rd_data_b,
    output logic [LOGN-2:0] tw_addr,
    input  logic [W-1:0]    tw_data,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr,
    output logic [W-1:0]    wr_data,
    output logic [W-1:0]    pe_a,
    output logic [W-1:0]    pe_b,
    output logic [W-1:0]    pe_c,
    output logic            pe_sub,
    input  logic [W-1:0]    pe_s
);

    localparam int SW = stage_w(LOGN);

    logic [2:0]      state;
    logic [SW-1:0]   stage;
    logic [LOGN-2:0] bf;
    logic [LOGN-1:0] sk;
    logic [W-1:0]    ra, rb, rw;
    logic [LOGN-1:0] ia, ib;
    logic [LOGN-2:0] t;
    logic            last_bf, last_stage;

    intt_addr_gen #(.LOGN(LOGN), .SW(SW)) u_addr (
        .stage (stage),
        .bf    (bf),
        .ia    (ia),
        .ib    (ib),
        .t     (t)
    );

    assign last_bf    = &bf;
    assign last_stage = (stage == SW'(LOGN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            bf    <= '0;
            sk    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RD;
                        stage <= '0;
                        bf    <= '0;
                    end
                end
                RD:  state <= SUM;
                SUM: state <= DIF;
                DIF: begin
                    // bf spans exactly NB values, so the increment wraps on its own.
                    bf <= bf + 1'b1;
                    if (!last_bf) begin
                        state <= RD;
                    end else if (!last_stage) begin
                        stage <= stage + 1'b1;
                        state <= RD;
                    end else begin
`ifdef INTT_SCALE_EN
                        sk    <= '0;
                        state <= SCL_RD;
`else
                        state <= DONE;
`endif
                    end
                end
                SCL_RD: state <= SCL_WR;
                SCL_WR: begin
                    sk    <= sk + 1'b1;
                    state <= (&sk) ? DONE : SCL_RD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The SUM write lands on ia only, so the pair captured here stays valid for DIF.
    always_ff @(posedge clk) begin
        if (state == SUM) begin
            ra <= rd_data_a;
            rb <= rd_data_b;
            rw <= tw_data;
        end
    end

    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        pe_a      = '0;
        pe_b      = '0;
        pe_c      = '0;
        pe_sub    = 1'b0;
        case (state)
            RD: begin
                rd_addr_a = ia;
                rd_addr_b = ib;
                tw_addr   = t;
            end
            SUM: begin
                pe_a    = rd_data_a;
                pe_b    = rd_data_b;
                pe_c    = W'(1);
                wr_en   = 1'b1;
                wr_addr = ia;
            end
            DIF: begin
                pe_a    = ra;
                pe_b    = rb;
                pe_c    = rw;
                pe_sub  = 1'b1;
                wr_en   = 1'b1;
                wr_addr = ib;
            end
            SCL_RD: rd_addr_a = sk;
            SCL_WR: begin
                pe_a    = rd_data_a;
                pe_c    = W'(N_INV);
                wr_en   = 1'b1;
                wr_addr = sk;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign wr_data = pe_s;

endmodule

// File: tb/tb_intt_sched.sv
// Bench for intt_sched with behavioural RAM, twiddle ROM and PE; compares against a
// textbook Gentleman-Sande INTT model. Honours INTT_SCALE_EN like the design.
module tb_intt_sched;

    localparam int W     = 9;
    localparam int LOGN  = 3;
    localparam int N     = 8;
    localparam int NH    = 4;
    localparam int Q     = 257;
    localparam int N_INV = 225;
`ifdef INTT_SCALE_EN
    localparam int SCALE = 1;
`else
    localparam int SCALE = 0;
`endif
    localparam int BF_CYC   = 3 * LOGN * NH;
    localparam int DONE_CYC = BF_CYC + 1 + SCALE * 2 * N;
    localparam int NWR      = LOGN * N + SCALE * N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, wr_en, pe_sub;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [LOGN-2:0] tw_addr;
    logic [W-1:0]    rd_data_a, rd_data_b, tw_data, wr_data;
    logic [W-1:0]    pe_a, pe_b, pe_c, pe_s;
    logic [50:0]     outs;

    logic [W-1:0] mem [N];
    logic [W-1:0] rom [NH];

    int vectors = 0;
    int errors  = 0;

    int cyc_done, n_wr, n_done;
    logic busy_after;
    logic [LOGN-1:0] cap_wa[$], cap_ia[$], cap_ib[$];
    logic [LOGN-2:0] cap_t[$];
    logic [LOGN-1:0] exp_ia[$], exp_ib[$];
    logic [LOGN-2:0] exp_t[$];
    int expv [N];

    always #5 clk = ~clk;

    intt_sched #(.W(W), .LOGN(LOGN), .N_INV(N_INV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .tw_addr(tw_addr), .tw_data(tw_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_sub(pe_sub), .pe_s(pe_s)
    );

    function automatic logic [W-1:0] pe_fn(input logic [W-1:0] a, b, c, input logic sub);
        int s;
        s = sub ? (int'(a) + Q - int'(b)) % Q : (int'(a) + int'(b)) % Q;
        return W'((s * int'(c)) % Q);
    endfunction

    assign pe_s = pe_fn(pe_a, pe_b, pe_c, pe_sub);
    assign outs = {busy, done, wr_en, pe_sub, rd_addr_a, rd_addr_b, tw_addr, wr_addr,
                   wr_data, pe_a, pe_b, pe_c};

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
        tw_data   <= rom[tw_addr];
    end

    // kind: 0 zero, 1 impulse at 0, 2 all ones, 3 random
    task automatic set_mem(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       mem[k] <= '0;
                1:       mem[k] <= (k == 0) ? W'(1) : W'(0);
                2:       mem[k] <= W'(1);
                default: mem[k] <= W'($urandom_range(Q - 1, 0));
            endcase
        end
        @(negedge clk);
    endtask

    task automatic set_rom(input bit unit);
        for (int k = 0; k < NH; k++)
            rom[k] = unit ? W'(1) : W'($urandom_range(Q - 1, 0));
    endtask

    // Textbook in-place GS inverse transform over the current RAM image.
    task automatic model_run();
        int x [N];
        int u, v, len;
        for (int k = 0; k < N; k++) x[k] = int'(mem[k]);
        exp_ia.delete(); exp_ib.delete(); exp_t.delete();
        for (int s = 0; s < LOGN; s++) begin
            len = 1 << s;
            for (int j = 0; j < N; j += 2 * len) begin
                for (int k = 0; k < len; k++) begin
                    u = x[j + k];
                    v = x[j + k + len];
                    x[j + k]       = (u + v) % Q;
                    x[j + k + len] = (((u - v + Q) % Q) * int'(rom[k * (NH / len)])) % Q;
                    exp_ia.push_back(LOGN'(j + k));
                    exp_ib.push_back(LOGN'(j + k + len));
                    exp_t.push_back((LOGN-1)'(k * (NH / len)));
                end
            end
        end
        for (int k = 0; k < N; k++) expv[k] = SCALE ? (x[k] * N_INV) % Q : x[k];
    endtask

    // Starts a transform; start is additionally held during cycles p1 and p2.
    task automatic run(input int p1, input int p2);
        model_run();
        cap_wa.delete(); cap_ia.delete(); cap_ib.delete(); cap_t.delete();
        n_wr = 0; n_done = 0; cyc_done = -1; busy_after = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 4; c++) begin
            @(negedge clk);
            if (wr_en) begin
                n_wr++;
                cap_wa.push_back(wr_addr);
            end
            if (c <= BF_CYC && c % 3 == 1) begin
                cap_ia.push_back(rd_addr_a);
                cap_ib.push_back(rd_addr_b);
                cap_t.push_back(tw_addr);
            end
            if (done) begin
                n_done++;
                if (cyc_done < 0) cyc_done = c;
            end
            if (c == DONE_CYC + 1) busy_after = busy;
            start = (c == p1) || (c == p2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_zero();
        set_rom(1'b0);
        set_mem(0);
        run(-1, -1);
        vectors++;
        if (cyc_done != DONE_CYC) begin errors++; $display("FAIL zero_done_cycle: got %0d expected %0d", cyc_done, DONE_CYC); end
        vectors++;
        if (n_wr != NWR) begin errors++; $display("FAIL zero_writes: got %0d expected %0d", n_wr, NWR); end
        vectors++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b expected 0", busy_after); end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (mem[k] !== '0) begin errors++; $display("FAIL zero_word%0d: got %0d expected 0", k, mem[k]); end
        end
    endtask

    task automatic test_impulse();
        int e;
        e = SCALE ? N_INV : 1;
        set_rom(1'b1);
        set_mem(1);
        run(-1, -1);
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (mem[k] !== W'(e)) begin errors++; $display("FAIL impulse_word%0d: got %0d expected %0d", k, mem[k], e); end
        end
    endtask

    task automatic test_const();
        int e;
        set_rom(1'b1);
        set_mem(2);
        run(-1, -1);
        for (int k = 0; k < N; k++) begin
            e = (k == 0) ? (SCALE ? 1 : N) : 0;
            vectors++;
            if (mem[k] !== W'(e)) begin errors++; $display("FAIL const_word%0d: got %0d expected %0d", k, mem[k], e); end
        end
    endtask

    task automatic test_trace();
        logic [LOGN-1:0] ew[$];
        set_rom(1'b0);
        set_mem(3);
        run(-1, -1);
        for (int i = 0; i < exp_ia.size(); i++) begin
            ew.push_back(exp_ia[i]);
            ew.push_back(exp_ib[i]);
        end
        for (int k = 0; k < N * SCALE; k++) ew.push_back(LOGN'(k));
        vectors++;
        if (cap_ia.size() != exp_ia.size() || cap_wa.size() != ew.size()) begin
            errors++;
            $display("FAIL trace_len: got rd %0d wr %0d expected rd %0d wr %0d",
                     cap_ia.size(), cap_wa.size(), exp_ia.size(), ew.size());
        end else begin
            for (int i = 0; i < exp_ia.size(); i++) begin
                vectors++;
                if (cap_ia[i] !== exp_ia[i] || cap_ib[i] !== exp_ib[i] || cap_t[i] !== exp_t[i]) begin
                    errors++;
                    $display("FAIL trace_rd%0d: got (%0d,%0d,t%0d) expected (%0d,%0d,t%0d)", i,
                             cap_ia[i], cap_ib[i], cap_t[i], exp_ia[i], exp_ib[i], exp_t[i]);
                end
            end
            for (int i = 0; i < ew.size(); i++) begin
                vectors++;
                if (cap_wa[i] !== ew[i]) begin errors++; $display("FAIL trace_wr%0d: got %0d expected %0d", i, cap_wa[i], ew[i]); end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            set_rom(1'b0);
            set_mem(3);
            run(-1, -1);
            vectors++;
            if (cyc_done != DONE_CYC) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", r, cyc_done, DONE_CYC); end
            for (int k = 0; k < N; k++) begin
                vectors++;
                if (mem[k] !== W'(expv[k])) begin errors++; $display("FAIL rand%0d_word%0d: got %0d expected %0d", r, k, mem[k], expv[k]); end
            end
        end
    endtask

    task automatic test_start_while_busy();
        set_rom(1'b0);
        set_mem(3);
        run(5, DONE_CYC);
        vectors++;
        if (n_done != 1 || cyc_done != DONE_CYC) begin
            errors++;
            $display("FAIL busy_start_done: got %0d pulses at %0d expected 1 at %0d", n_done, cyc_done, DONE_CYC);
        end
        vectors++;
        if (n_wr != NWR) begin errors++; $display("FAIL busy_start_writes: got %0d expected %0d", n_wr, NWR); end
        vectors++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_start_restart: got busy %b expected 0", busy_after); end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (mem[k] !== W'(expv[k])) begin errors++; $display("FAIL busy_start_word%0d: got %0d expected %0d", k, mem[k], expv[k]); end
        end
    endtask

    task automatic test_reset_mid_run();
        set_rom(1'b0);
        set_mem(3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(-1, -1);
        vectors++;
        if (cyc_done != DONE_CYC || n_wr != NWR) begin
            errors++;
            $display("FAIL midrst_rerun: got done %0d writes %0d expected %0d %0d", cyc_done, n_wr, DONE_CYC, NWR);
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (mem[k] !== W'(expv[k])) begin errors++; $display("FAIL midrst_word%0d: got %0d expected %0d", k, mem[k], expv[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_const();
        test_trace();
        test_random();
        test_start_while_busy();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
